// File: rtl/pe_row_pkg.sv
// Shared constants, FSM state type and small helpers for the 16-PE row sequencer.
package pe_row_pkg;

  localparam int NUM_PE    = 16;
  localparam int DW        = 8;
  localparam int CAST_BASE = 3;
  localparam int NUM_CAST  = 3;

  localparam logic [1:0] MODE_NORMAL = 2'd0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } pe_row_state_e;

  // Broadcast pixels only reach PEs CAST_BASE..CAST_BASE+NUM_CAST-1 outside normal mode.
  function automatic logic cast_enabled(input logic [1:0] m);
    return m != MODE_NORMAL;
  endfunction

endpackage

// File: rtl/pe_row_wload.sv
// Weight loader: sweeps the weight buffer once per job and keeps the row's
// weights in a register file that holds until the next job reloads it.
module pe_row_wload #(
  parameter int NUM_PE = pe_row_pkg::NUM_PE,
  parameter int DW     = pe_row_pkg::DW
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          w_rd,
  output logic [$clog2(NUM_PE)-1:0]     w_addr,
  input  logic [DW-1:0]                 w_data,
  output logic [NUM_PE-1:0][DW-1:0]     weight,
  output logic                          loaded
);
  import pe_row_pkg::*;

  localparam int AW = $clog2(NUM_PE);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_PE - 1);

  logic          rd_p1;
  logic [AW-1:0] addr_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_rd   <= 1'b0;
      w_addr <= '0;
    end else if (start) begin
      w_rd   <= 1'b1;
      w_addr <= '0;
    end else if (w_rd) begin
      if (w_addr == LAST_ADDR) begin
        w_rd <= 1'b0;
      end else begin
        w_addr <= w_addr + AW'(1);
      end
    end
  end

  // p1: buffer read latency, data arrives one cycle after the strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_p1   <= 1'b0;
      addr_p1 <= '0;
    end else begin
      rd_p1   <= w_rd;
      addr_p1 <= w_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weight <= '0;
    end else if (rd_p1) begin
      weight[addr_p1] <= w_data;
    end
  end

  assign loaded = rd_p1 && (addr_p1 == LAST_ADDR);

endmodule

// File: rtl/pe_row_ctrl.sv
// Sequencer for one convolution row: accepts a job, loads weights, streams
// pixel vectors under valid/ready and flags cycles carrying valid PE products.
module pe_row_ctrl #(
  parameter int NUM_PE = pe_row_pkg::NUM_PE,
  parameter int DW     = pe_row_pkg::DW,
  parameter int LEN_W  = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         cfg_valid,
  output logic                                         cfg_ready,
  input  logic [1:0]                                   cfg_mode,
  input  logic [LEN_W-1:0]                             cfg_len,
  output logic                                         w_rd,
  output logic [$clog2(NUM_PE)-1:0]                    w_addr,
  input  logic [DW-1:0]                                w_data,
  input  logic                                         pix_in_valid,
  output logic                                         pix_in_ready,
  input  logic [NUM_PE-1:0][DW-1:0]                    pix_in,
  input  logic [pe_row_pkg::NUM_CAST-1:0][DW-1:0]      pix_cast_in,
  output logic [1:0]                                   mode,
  output logic [NUM_PE-1:0][DW-1:0]                    pixel,
  output logic [pe_row_pkg::NUM_CAST-1:0][DW-1:0]      pixel_cast,
  output logic [NUM_PE-1:0][DW-1:0]                    weight,
  output logic                                         prod_valid,
  output logic                                         busy,
  output logic                                         done
);
  import pe_row_pkg::*;

  pe_row_state_e    state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic             start;
  logic             loaded;
  logic             accept;
  logic             last_beat;
  logic             vld_p1;
  logic             vld_p2;

  assign start        = (state == IDLE) && cfg_valid;
  assign pix_in_ready = (state == STREAM) && (beat_cnt < len_q);
  assign accept       = pix_in_valid && pix_in_ready;
  assign last_beat    = accept && ((beat_cnt + LEN_W'(1)) == len_q);
  assign prod_valid   = vld_p2;

  pe_row_wload #(
    .NUM_PE (NUM_PE),
    .DW     (DW)
  ) u_wload (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .w_rd   (w_rd),
    .w_addr (w_addr),
    .w_data (w_data),
    .weight (weight),
    .loaded (loaded)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      mode      <= MODE_NORMAL;
      len_q     <= '0;
      beat_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            mode      <= cfg_mode;
            len_q     <= cfg_len;
            beat_cnt  <= '0;
            cfg_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= LOAD_W;
          end
        end
        LOAD_W: begin
          if (loaded) begin
            if (len_q == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (last_beat) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The last token sits in p1 on the first drain cycle, so this exits after two.
          if (!vld_p1) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // p0: accepted pixel vector handed to the PE row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel      <= '0;
      pixel_cast <= '0;
    end else if (accept) begin
      pixel      <= pix_in;
      pixel_cast <= cast_enabled(mode) ? pix_cast_in : '0;
    end
  end

  // p1/p2: accept tokens follow the PE product register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      vld_p2 <= vld_p1;
    end
  end

endmodule

// File: tb/tb_pe_row_ctrl.sv
// Randomized bench for pe_row_ctrl against a job-timeline reference model.
module tb_pe_row_ctrl;
  localparam int NUM_PE = 16;
  localparam int DW     = 8;
  localparam int LEN_W  = 8;
  localparam int NC     = 3;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       cfg_valid;
  logic                       cfg_ready;
  logic [1:0]                 cfg_mode;
  logic [LEN_W-1:0]           cfg_len;
  logic                       w_rd;
  logic [3:0]                 w_addr;
  logic [DW-1:0]              w_data;
  logic                       pix_in_valid;
  logic                       pix_in_ready;
  logic [NUM_PE-1:0][DW-1:0]  pix_in;
  logic [NC-1:0][DW-1:0]      pix_cast_in;
  logic [1:0]                 mode;
  logic [NUM_PE-1:0][DW-1:0]  pixel;
  logic [NC-1:0][DW-1:0]      pixel_cast;
  logic [NUM_PE-1:0][DW-1:0]  weight;
  logic                       prod_valid;
  logic                       busy;
  logic                       done;

  pe_row_ctrl #(.NUM_PE(NUM_PE), .DW(DW), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_len(cfg_len), .w_rd(w_rd), .w_addr(w_addr),
    .w_data(w_data), .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready),
    .pix_in(pix_in), .pix_cast_in(pix_cast_in), .mode(mode), .pixel(pixel),
    .pixel_cast(pixel_cast), .weight(weight), .prod_valid(prod_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model: job timeline relative to the handshake cycle
  bit                        m_busy = 1'b0;
  int                        m_h = -100;
  int                        m_len = 0;
  int                        m_acc = 0;
  int                        m_done_cyc = -1;
  logic [1:0]                m_mode = '0;
  logic [1:0]                exp_mode = '0;
  logic [NUM_PE-1:0][DW-1:0] exp_pixel = '0;
  logic [NUM_PE-1:0][DW-1:0] exp_weight = '0;
  logic [NC-1:0][DW-1:0]     exp_cast = '0;
  logic [DW-1:0]             wmem [NUM_PE];
  bit                        acc_log [0:16383];

  // stimulus knobs
  int         hs_pending = 0;
  int         job_len = 0;
  logic [1:0] job_mode = '0;
  int         pv_prob = 100;
  bit         use_q = 1'b0;
  bit         pv_q [$];
  bit         dir_w = 1'b0;
  bit         cast_fixed = 1'b0;
  bit         prev_rd = 1'b0;
  logic [3:0] prev_addr = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic cycle();
    int rel;
    bit exp_wrd, exp_rdy, pv, cv, acc;
    @(negedge clk);
    cyc++;
    rel     = cyc - m_h;
    exp_wrd = m_busy && rel >= 1 && rel <= 16;
    exp_rdy = m_busy && m_len > 0 && rel >= 18 && m_acc < m_len;
    chk("cfg_ready",    128'(cfg_ready),    128'(!m_busy));
    chk("busy",         128'(busy),         128'(m_busy));
    chk("done",         128'(done),         128'(m_busy && cyc == m_done_cyc));
    chk("prod_valid",   128'(prod_valid),   128'(cyc >= 2 && acc_log[cyc-2]));
    chk("pix_in_ready", 128'(pix_in_ready), 128'(exp_rdy));
    chk("w_rd",         128'(w_rd),         128'(exp_wrd));
    if (exp_wrd) chk("w_addr", 128'(w_addr), 128'(rel - 1));
    chk("mode",         128'(mode),         128'(exp_mode));
    chk("pixel",        128'(pixel),        128'(exp_pixel));
    chk("pixel_cast",   128'(pixel_cast),   128'(exp_cast));
    chk("weight",       128'(weight),       128'(exp_weight));

    // weight buffer answers one cycle after the strobe
    w_data    = prev_rd ? wmem[prev_addr] : DW'($urandom);
    prev_rd   = w_rd;
    prev_addr = w_addr;

    cv        = hs_pending > 0;
    cfg_valid = cv;
    cfg_mode  = cv ? job_mode : 2'($urandom);
    cfg_len   = cv ? LEN_W'(job_len) : LEN_W'($urandom);
    if (use_q) begin
      pv = 1'b0;
      if (exp_rdy && pv_q.size() > 0) pv = pv_q.pop_front();
    end else begin
      pv = ($urandom_range(99) < pv_prob);
    end
    pix_in_valid = pv;
    for (int i = 0; i < NUM_PE; i++) pix_in[i] = DW'($urandom);
    for (int i = 0; i < NC; i++) pix_cast_in[i] = cast_fixed ? 8'hAA : DW'($urandom);

    acc = exp_rdy && pv;
    if (acc) begin
      acc_log[cyc] = 1'b1;
      exp_pixel    = pix_in;
      exp_cast     = (m_mode != 2'd0) ? pix_cast_in : '0;
      m_acc++;
      if (m_acc == m_len) m_done_cyc = cyc + 3;
    end
    if (m_busy && rel >= 2 && rel <= 17) exp_weight[rel-2] = wmem[rel-2];
    if (m_busy && cyc == m_done_cyc) begin
      m_busy = 1'b0;
    end else if (!m_busy && cv) begin
      m_busy     = 1'b1;
      m_h        = cyc;
      m_len      = job_len;
      m_mode     = job_mode;
      exp_mode   = job_mode;
      m_acc      = 0;
      m_done_cyc = (job_len == 0) ? cyc + 18 : -1;
      for (int i = 0; i < NUM_PE; i++) wmem[i] = dir_w ? DW'(i + 1) : DW'($urandom);
      hs_pending--;
    end
  endtask

  task automatic run_job(input int len, input logic [1:0] md, input int nhs, input int prob);
    int n = 0;
    job_len    = len;
    job_mode   = md;
    hs_pending = nhs;
    pv_prob    = prob;
    while ((hs_pending > 0 || m_busy) && n < 1500) begin
      cycle();
      n++;
    end
    chk("job_bound", 128'(n < 1500), 128'(1));
    cycle();
    cycle();
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_cfg_ready"},    128'(cfg_ready),    128'(1));
    chk({pfx, "_busy"},         128'(busy),         128'(0));
    chk({pfx, "_done"},         128'(done),         128'(0));
    chk({pfx, "_prod_valid"},   128'(prod_valid),   128'(0));
    chk({pfx, "_w_rd"},         128'(w_rd),         128'(0));
    chk({pfx, "_pix_in_ready"}, 128'(pix_in_ready), 128'(0));
    chk({pfx, "_w_addr"},       128'(w_addr),       128'(0));
    chk({pfx, "_mode"},         128'(mode),         128'(0));
    chk({pfx, "_pixel"},        128'(pixel),        128'(0));
    chk({pfx, "_pixel_cast"},   128'(pixel_cast),   128'(0));
    chk({pfx, "_weight"},       128'(weight),       128'(0));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset_values("arst");
    m_busy     = 1'b0;
    m_done_cyc = -1;
    hs_pending = 0;
    exp_pixel  = '0;
    exp_cast   = '0;
    exp_weight = '0;
    exp_mode   = '0;
    prev_rd    = 1'b0;
    foreach (acc_log[i]) acc_log[i] = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  initial begin
    int n;
    rst          = 1'b1;
    cfg_valid    = 1'b0;
    cfg_mode     = '0;
    cfg_len      = '0;
    w_data       = '0;
    pix_in_valid = 1'b0;
    pix_in       = '0;
    pix_cast_in  = '0;
    for (int i = 0; i < NUM_PE; i++) wmem[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc++;
    check_reset_values("rst0");
    rst = 1'b0;
    cycle();

    // directed job: len 4, mode 3, weights i+1, no stalls
    dir_w = 1'b1;
    run_job(4, 2'd3, 1, 100);
    chk("weight15", 128'(weight[15]), 128'(16));
    dir_w = 1'b0;

    // reset in the middle of streaming, after two of five beats
    job_len    = 5;
    job_mode   = 2'd2;
    hs_pending = 1;
    pv_prob    = 100;
    n = 0;
    while (!(m_busy && m_acc == 2) && n < 200) begin
      cycle();
      n++;
    end
    chk("rst_mid_bound", 128'(n < 200), 128'(1));
    do_reset();
    repeat (3) cycle();

    // normal mode with a fixed nonzero broadcast input
    cast_fixed = 1'b1;
    run_job(5, 2'd0, 1, 70);
    cast_fixed = 1'b0;

    // gapped valid pattern 1,0,1,0,1
    use_q = 1'b1;
    pv_q  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    run_job(3, 2'd1, 1, 100);
    use_q = 1'b0;

    // empty job
    run_job(0, 2'd2, 1, 100);

    // descriptor held valid across a job
    run_job(2, 2'd1, 2, 100);

    for (int j = 0; j < 24; j++) begin
      cast_fixed = ($urandom_range(3) == 0);
      run_job(int'($urandom_range(12)), 2'($urandom), 1, int'($urandom_range(30, 100)));
    end
    cast_fixed = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
